// File: rtl/finder_pattern_scanner.sv
// ============================================================================
// finder_pattern_scanner
// Scans a binarised frame row-major then column-major and marks the centres
// of QR finder runs (1:1:3:1:1) in horz_patterns / vert_patterns.
// Revision: 1.0
// ============================================================================
`default_nettype none

module finder_pattern_scanner #(
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_scan,
    input  logic              pixel_reading,
    output logic [19:0]       address_reading,
    output logic [WIDTH-1:0]  horz_patterns,
    output logic [HEIGHT-1:0] vert_patterns,
    output logic              start_cross,
    output logic              busy
);

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_HSCAN = 3'd1;
    localparam logic [2:0]  S_VSCAN = 3'd2;
    localparam logic [2:0]  S_DRAIN = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;
    localparam logic [8:0]  X_LAST  = 9'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST  = 9'(HEIGHT - 1);
    localparam logic [19:0] ROW_STEP = 20'(WIDTH);
    localparam int          TAG_W   = 13;

    logic [2:0] state, next_state;
    logic [8:0] x_cnt, y_cnt;
    logic       scanning, scan_last, accept;

    assign scanning  = (state == S_HSCAN) || (state == S_VSCAN);
    assign scan_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign accept    = (state == S_IDLE) && start_scan;

    // Read pipeline tag: {valid, phase, line_start, line_end, position}
    logic [READ_LATENCY*TAG_W-1:0] pipe;
    logic [TAG_W-1:0] tag_in, tag_out;
    logic             pipe_busy;
    logic             check;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_scan) next_state = S_HSCAN;
            S_HSCAN: if (scan_last)  next_state = S_VSCAN;
            S_VSCAN: if (scan_last)  next_state = S_DRAIN;
            S_DRAIN: if (!pipe_busy) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        start_cross = (state == S_DONE);
    end

    // Address generation: row-major increments by 1, column-major by WIDTH
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_cnt <= '0; y_cnt <= '0; address_reading <= '0;
        end else if (accept || (scanning && scan_last)) begin
            x_cnt <= '0; y_cnt <= '0; address_reading <= '0;
        end else if (state == S_HSCAN) begin
            address_reading <= address_reading + 20'd1;
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 9'd1;
            end else begin
                x_cnt <= x_cnt + 9'd1;
            end
        end else if (state == S_VSCAN) begin
            if (y_cnt == Y_LAST) begin
                y_cnt           <= '0;
                x_cnt           <= x_cnt + 9'd1;
                address_reading <= 20'(x_cnt) + 20'd1;
            end else begin
                y_cnt           <= y_cnt + 9'd1;
                address_reading <= address_reading + ROW_STEP;
            end
        end
    end

    always_comb begin
        if (state == S_VSCAN)
            tag_in = {scanning, 1'b1, (y_cnt == 9'd0), (y_cnt == Y_LAST), y_cnt};
        else
            tag_in = {scanning, 1'b0, (x_cnt == 9'd0), (x_cnt == X_LAST), x_cnt};
    end

    generate
        if (READ_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) pipe <= '0;
                else         pipe <= tag_in;
            end
        end else begin : g_pipe_shift
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) pipe <= '0;
                else         pipe <= {pipe[(READ_LATENCY-1)*TAG_W-1:0], tag_in};
            end
        end
    endgenerate

    assign tag_out = pipe[READ_LATENCY*TAG_W-1 -: TAG_W];

    always_comb begin
        pipe_busy = check;
        for (int i = 0; i < READ_LATENCY; i++)
            pipe_busy = pipe_busy | pipe[i*TAG_W + TAG_W - 1];
    end

    // Run-length encoder; history index 4 is the newest run
    logic            a_valid, a_phase, a_first, a_last;
    logic [8:0]      a_pos;
    logic [8:0]      run_len, run_len_n, len_inc, old_len, old_pos;
    logic            run_color, run_color_n;
    logic [4:0][8:0] hist_len, hist_len_n;
    logic [4:0]      hist_color, hist_color_n;
    logic [2:0]      hist_cnt, hist_cnt_n;
    logic [8:0]      newest_pos, newest_pos_n;
    logic            check_n, check_phase, check_phase_n;
    logic            clear, push_old, push_new;

    assign {a_valid, a_phase, a_first, a_last, a_pos} = tag_out;
    assign len_inc = (run_len == 9'd511) ? run_len : run_len + 9'd1;

    always_comb begin
        clear = 1'b0; push_old = 1'b0; push_new = 1'b0;
        old_len = run_len; old_pos = a_pos - 9'd1;
        run_len_n = run_len; run_color_n = run_color;
        check_phase_n = check_phase;
        if (a_valid) begin
            check_phase_n = a_phase;
            if (a_first) begin
                clear = 1'b1; run_len_n = 9'd1; run_color_n = pixel_reading;
                push_new = a_last;
            end else if (pixel_reading == run_color) begin
                run_len_n = len_inc;
                if (a_last) begin
                    push_old = 1'b1; old_len = len_inc; old_pos = a_pos;
                end
            end else begin
                run_len_n = 9'd1; run_color_n = pixel_reading; push_old = 1'b1;
                // A trailing single white pixel can never end a pattern, so it is dropped
                push_new = a_last && !pixel_reading;
            end
        end
        hist_len_n   = clear ? '0 : hist_len;
        hist_color_n = clear ? '0 : hist_color;
        hist_cnt_n   = clear ? 3'd0 : hist_cnt;
        newest_pos_n = newest_pos;
        if (push_old) begin
            hist_len_n   = {old_len, hist_len_n[4:1]};
            hist_color_n = {run_color, hist_color_n[4:1]};
            hist_cnt_n   = (hist_cnt_n == 3'd5) ? 3'd5 : hist_cnt_n + 3'd1;
            newest_pos_n = old_pos;
        end
        if (push_new) begin
            hist_len_n   = {9'd1, hist_len_n[4:1]};
            hist_color_n = {pixel_reading, hist_color_n[4:1]};
            hist_cnt_n   = (hist_cnt_n == 3'd5) ? 3'd5 : hist_cnt_n + 3'd1;
            newest_pos_n = a_pos;
        end
        check_n = (push_old || push_new) && !hist_color_n[4];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            run_len <= '0; run_color <= 1'b0; hist_len <= '0; hist_color <= '0;
            hist_cnt <= '0; newest_pos <= '0; check <= 1'b0; check_phase <= 1'b0;
        end else begin
            run_len <= run_len_n; run_color <= run_color_n; hist_len <= hist_len_n;
            hist_color <= hist_color_n; hist_cnt <= hist_cnt_n; newest_pos <= newest_pos_n;
            check <= check_n; check_phase <= check_phase_n;
        end
    end

    // Ratio test on the registered history, one cycle after the black run completes
    function automatic logic side_ok(input logic [8:0] r, input logic [15:0] s);
        return (16'(r) * 16'd14 >= s) && (16'(r) * 16'd14 <= s * 16'd3);
    endfunction

    logic [11:0] sum12;
    logic [15:0] sum16;
    logic [9:0]  center;
    logic        hit;
    logic [WIDTH-1:0]  horz_set;
    logic [HEIGHT-1:0] vert_set;

    always_comb begin
        sum12  = 12'(hist_len[0]) + 12'(hist_len[1]) + 12'(hist_len[2])
               + 12'(hist_len[3]) + 12'(hist_len[4]);
        sum16  = 16'(sum12);
        center = 10'(newest_pos) - 10'(hist_len[4]) - 10'(hist_len[3])
               - 10'(hist_len[2] >> 1);
        hit    = check && (hist_cnt == 3'd5) && (hist_color == 5'b01010)
              && (sum12 >= 12'd7)
              && side_ok(hist_len[0], sum16) && side_ok(hist_len[1], sum16)
              && side_ok(hist_len[3], sum16) && side_ok(hist_len[4], sum16)
              && (16'(hist_len[2]) * 16'd7 >= sum16 * 16'd2)
              && (16'(hist_len[2]) * 16'd7 <= sum16 * 16'd4);
        for (int i = 0; i < WIDTH; i++)
            horz_set[i] = hit && !check_phase && (center == 10'(i));
        for (int i = 0; i < HEIGHT; i++)
            vert_set[i] = hit && check_phase && (center == 10'(i));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else if (accept) begin
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else begin
            horz_patterns <= horz_patterns | horz_set;
            vert_patterns <= vert_patterns | vert_set;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_finder_pattern_scanner.sv
// ============================================================================
// tb_finder_pattern_scanner
// Scoreboard bench: frame-level reference model versus DUT pattern vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_finder_pattern_scanner;

    localparam int W  = 48;
    localparam int H  = 40;
    localparam int RL = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_scan;
    logic          pixel_reading;
    logic [19:0]   address_reading;
    logic [W-1:0]  horz_patterns;
    logic [H-1:0]  vert_patterns;
    logic          start_cross;
    logic          busy;

    finder_pattern_scanner #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_scan      (start_scan),
        .pixel_reading   (pixel_reading),
        .address_reading (address_reading),
        .horz_patterns   (horz_patterns),
        .vert_patterns   (vert_patterns),
        .start_cross     (start_cross),
        .busy            (busy)
    );

    always #5 clk_in = ~clk_in;

    // Frame buffer with a two-stage registered read
    bit   mem [W*H];
    logic rd1, rd2;
    always @(posedge clk_in) begin
        rd1 <= (address_reading < 20'(W*H)) ? mem[address_reading] : 1'b1;
        rd2 <= rd1;
    end
    assign pixel_reading = rd2;

    typedef struct packed {
        logic [W-1:0] h;
        logic [H-1:0] v;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   frames_done = 0;
    int   sc_count = 0;
    int   exp_pulses = 0;
    int   busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: run lists per line ----------------
    bit line_buf [512];

    function automatic logic [511:0] line_mask(input int n);
        int rl[$]; int re[$]; bit rc[$];
        int s, c;
        logic [511:0] m = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || line_buf[i] != rc[rc.size()-1]) begin
                rl.push_back(1); re.push_back(i); rc.push_back(line_buf[i]);
            end else begin
                rl[rl.size()-1] += 1;
                re[re.size()-1] = i;
            end
        end
        for (int k = 4; k < rl.size(); k++) begin
            if (rc[k] == 0 && rc[k-1] == 1 && rc[k-2] == 0 && rc[k-3] == 1 && rc[k-4] == 0) begin
                s = rl[k] + rl[k-1] + rl[k-2] + rl[k-3] + rl[k-4];
                if (s >= 7
                    && 14*rl[k-4] >= s && 14*rl[k-4] <= 3*s
                    && 14*rl[k-3] >= s && 14*rl[k-3] <= 3*s
                    && 14*rl[k-1] >= s && 14*rl[k-1] <= 3*s
                    && 14*rl[k]   >= s && 14*rl[k]   <= 3*s
                    && 7*rl[k-2] >= 2*s && 7*rl[k-2] <= 4*s) begin
                    c = re[k] - rl[k] - rl[k-1] - rl[k-2] / 2;
                    m[c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic exp_t model_frame();
        exp_t e = '0;
        logic [511:0] lm;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) line_buf[x] = mem[y*W + x];
            lm  = line_mask(W);
            e.h = e.h | lm[W-1:0];
        end
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) line_buf[y] = mem[y*W + x];
            lm  = line_mask(H);
            e.v = e.v | lm[H-1:0];
        end
        return e;
    endfunction

    // ---------------- frame builders ----------------
    task automatic fill_white();
        for (int i = 0; i < W*H; i++) mem[i] = 1'b1;
    endtask

    task automatic fill_noise_runs();
        bit col;
        int x, len;
        for (int y = 0; y < H; y++) begin
            col = 1'($urandom_range(0, 1));
            x = 0;
            while (x < W) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len && x < W; k++) begin
                    mem[y*W + x] = col;
                    x++;
                end
                col = !col;
            end
        end
    endtask

    task automatic draw_finder(input int x0, input int y0, input int m);
        int mx, my;
        bit black;
        for (int dy = 0; dy < 7*m; dy++)
            for (int dx = 0; dx < 7*m; dx++) begin
                mx = dx / m; my = dy / m;
                black = (mx == 0 || mx == 6 || my == 0 || my == 6)
                     || (mx >= 2 && mx <= 4 && my >= 2 && my <= 4);
                mem[(y0+dy)*W + x0 + dx] = !black;
            end
    endtask

    task automatic draw_short_stripe();
        for (int y = 5; y <= 15; y++)
            for (int x = 5; x < 20; x++)
                mem[y*W + x] = (((x - 5) / 3) % 2) == 1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (!rst_in) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (start_cross) begin
                sc_count++;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_start_cross: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("horz_patterns", 64'(horz_patterns), 64'(e.h));
                    chk("vert_patterns", 64'(vert_patterns), 64'(e.v));
                    chk("busy_time_in_range",
                        64'((busy_cnt >= 2*W*H) && (busy_cnt <= 2*W*H + RL + 6)), 64'd1);
                end
                frames_done++;
                busy_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_frame(input bit restart_mid, input bit abort_mid);
        int target;
        sb.push_back(model_frame());
        target = frames_done + 1;
        @(posedge clk_in); #1 start_scan = 1'b1;
        @(posedge clk_in); #1 start_scan = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (restart_mid) begin
            repeat (150) @(posedge clk_in);
            #1 start_scan = 1'b1;
            @(posedge clk_in); #1 start_scan = 1'b0;
        end
        if (abort_mid) begin
            repeat (W*H + 100) @(posedge clk_in);
            #2 rst_in = 1'b0;
            #1;
            chk("abort_address", 64'(address_reading), 64'd0);
            chk("abort_horz", 64'(horz_patterns), 64'd0);
            chk("abort_vert", 64'(vert_patterns), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_start_cross", 64'(start_cross), 64'd0);
            sb.delete();
            repeat (3) @(posedge clk_in);
            #1 rst_in = 1'b1;
            repeat (5) @(posedge clk_in);
            return;
        end
        exp_pulses++;
        for (int i = 0; i < 2*W*H + 200; i++) begin
            if (frames_done >= target) break;
            @(posedge clk_in);
        end
        #1;
        chk("frame_completed", 64'(frames_done >= target), 64'd1);
        if (frames_done >= target) chk("busy_dropped", 64'(busy), 64'd0);
        repeat (3) @(posedge clk_in);
    endtask

    initial begin
        rst_in = 1'b0;
        start_scan = 1'b0;
        fill_white();
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_address", 64'(address_reading), 64'd0);
        chk("reset_horz", 64'(horz_patterns), 64'd0);
        chk("reset_vert", 64'(vert_patterns), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_start_cross", 64'(start_cross), 64'd0);
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);

        fill_white();                             run_frame(0, 0);
        fill_white(); draw_finder(10, 12, 3);     run_frame(0, 0);
        fill_white(); draw_short_stripe();        run_frame(0, 0);
        fill_white(); draw_finder(27, 19, 3);     run_frame(0, 0);
        fill_white(); draw_finder(10, 12, 3);     run_frame(1, 0);
        fill_white(); draw_finder(10, 12, 3);     run_frame(0, 1);
        chk("no_start_cross_after_abort", 64'(sc_count), 64'(exp_pulses));
        run_frame(0, 0);

        for (int r = 0; r < 5; r++) begin
            int m1, m2;
            m1 = int'($urandom_range(1, 2));
            m2 = int'($urandom_range(1, 2));
            if (r % 2 == 0) fill_noise_runs();
            else            fill_white();
            draw_finder(int'($urandom_range(0, W - 7*m1)), int'($urandom_range(0, H - 7*m1)), m1);
            if (r % 2 == 1)
                draw_finder(int'($urandom_range(0, W - 7*m2)), int'($urandom_range(0, H - 7*m2)), m2);
            run_frame(0, 0);
        end

        repeat (10) @(posedge clk_in);
        #1;
        chk("start_cross_count", 64'(sc_count), 64'(exp_pulses));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
